ram_arbiter: RTL and testbench

- Shares the single-port 256x16 synchronous-read RAM between two requesters: port 0 (CPU fetch/load/store path) and port 1 (loader/debug engine).
- Performs at most one RAM access per cycle.
- Arbitrates round-robin, with an optional bounded lock (burst) so a requester can hold the RAM for consecutive cycles.
- Returns read data with the RAM's one-cycle latency, tagged by a per-port valid.

---
 rtl/ram_arbiter_if.sv | 18 +
 rtl/ram_arbiter.sv | 110 +++++++++++
 tb/tb_ram_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// One requester's view of the shared RAM: request/write/lock bus plus
// grant and read-return signals.
interface ram_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              req;
  logic              we;
  logic              lock;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, lock, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, lock, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter with bounded lock bursts sharing one single-port
// synchronous-read RAM between two requesters.
//
// state | meaning
// IDLE  | no owner; tie goes to the port that did not win last
// OWN0  | port 0 holds a lock; keeps winning until burst limit with contention
// OWN1  | port 1 holds a lock; same rules mirrored
module ram_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  ram_arbiter_if.slave      p0,
  ram_arbiter_if.slave      p1,
  output logic              ram_w_en,
  output logic [ADDR_W-1:0] ram_r_addr,
  output logic [ADDR_W-1:0] ram_w_addr,
  output logic [DATA_W-1:0] ram_w_data,
  input  logic [DATA_W-1:0] ram_r_data
);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             last_winner, last_winner_nxt;
  logic             win0, win1;
  logic             rvalid0, rvalid1;
  logic             sel1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      last_winner <= 1'b1;
      rvalid0     <= 1'b0;
      rvalid1     <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      last_winner <= last_winner_nxt;
      rvalid0     <= win0 & ~p0.we;
      rvalid1     <= win1 & ~p1.we;
    end
  end

  assign cnt_inc = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_W'(1);

  always_comb begin
    win0            = 1'b0;
    win1            = 1'b0;
    state_nxt       = IDLE;
    cnt_nxt         = '0;
    last_winner_nxt = last_winner;

    case (state)
      OWN0: begin
        if (p0.req && (cnt < CNT_MAX || !p1.req)) win0 = 1'b1;
        else                                      win1 = p1.req;
      end
      OWN1: begin
        if (p1.req && (cnt < CNT_MAX || !p0.req)) win1 = 1'b1;
        else                                      win0 = p0.req;
      end
      default: begin
        if (p0.req && p1.req) begin
          win0 = last_winner;
          win1 = ~last_winner;
        end else begin
          win0 = p0.req;
          win1 = p1.req;
        end
      end
    endcase

    // Burst count restarts at 1 whenever ownership changes hands.
    if (win0) begin
      last_winner_nxt = 1'b0;
      if (p0.lock) begin
        state_nxt = OWN0;
        cnt_nxt   = (state == OWN0) ? cnt_inc : CNT_W'(1);
      end
    end else if (win1) begin
      last_winner_nxt = 1'b1;
      if (p1.lock) begin
        state_nxt = OWN1;
        cnt_nxt   = (state == OWN1) ? cnt_inc : CNT_W'(1);
      end
    end
  end

  // Idle cycles keep the bus pointed at the most recent winner.
  assign sel1 = win1 | (~win0 & last_winner);

  assign p0.gnt     = win0 & ~rst;
  assign p1.gnt     = win1 & ~rst;
  assign ram_w_en   = ((win0 & p0.we) | (win1 & p1.we)) & ~rst;
  assign ram_r_addr = sel1 ? p1.addr : p0.addr;
  assign ram_w_addr = ram_r_addr;
  assign ram_w_data = sel1 ? p1.wdata : p0.wdata;

  assign p0.rvalid = rvalid0;
  assign p1.rvalid = rvalid1;
  assign p0.rdata  = ram_r_data;
  assign p1.rdata  = ram_r_data;
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural RAM and a queue-based
// scoreboard for grants and read returns.
module tb_ram_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam logic [1:0] GN = 2'b00;
  localparam logic [1:0] G0 = 2'b01;
  localparam logic [1:0] G1 = 2'b10;

  typedef struct {
    int          cyc;
    logic [1:0]  g;
    logic        wen;
    logic [7:0]  addr;
  } grec_t;

  typedef struct {
    int          cyc;
    int          port;
    logic [15:0] data;
  } rrec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic preload = 1'b1;
  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) p0_if ();
  ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) p1_if ();

  logic          ram_w_en;
  logic [AW-1:0] ram_r_addr, ram_w_addr;
  logic [DW-1:0] ram_w_data, ram_r_data;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .p0         (p0_if),
    .p1         (p1_if),
    .ram_w_en   (ram_w_en),
    .ram_r_addr (ram_r_addr),
    .ram_w_addr (ram_w_addr),
    .ram_w_data (ram_w_data),
    .ram_r_data (ram_r_data)
  );

  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[8'h05] <= 16'h1234;
      mem[8'h06] <= 16'h5A5A;
      mem[8'h50] <= 16'h0BAD;
      for (int i = 0; i < 3; i++) begin
        mem[8'(32'h20 + i)] <= 16'h2000 + 16'(i);
        mem[8'(32'h30 + i)] <= 16'h3000 + 16'(i);
      end
    end else if (ram_w_en) begin
      mem[ram_w_addr] <= ram_w_data;
    end
    ram_r_data <= mem[ram_r_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  grec_t gq[$];
  rrec_t rq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    grec_t g;
    rrec_t r;
    if (gq.size() > 0) begin
      g = gq.pop_front();
      check("gnt", 32'({p1_if.gnt, p0_if.gnt}), 32'(g.g));
      check("w_en", 32'(ram_w_en), 32'(g.wen));
      if (g.g != GN) begin
        check("r_addr", 32'(ram_r_addr), 32'(g.addr));
        check("w_addr", 32'(ram_w_addr), 32'(g.addr));
      end
    end
    if (p0_if.rvalid || p1_if.rvalid) begin
      if (rq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rvalid: got p0=%b p1=%b, expected none (cycle %0d)",
                 p0_if.rvalid, p1_if.rvalid, cyc);
      end else begin
        r = rq.pop_front();
        check("rvalid_cycle", 32'(cyc), 32'(r.cyc));
        check("rvalid_port", 32'({p1_if.rvalid, p0_if.rvalid}), (r.port == 0) ? 32'd1 : 32'd2);
        check("rdata", 32'((r.port == 0) ? p0_if.rdata : p1_if.rdata), 32'(r.data));
      end
    end
  end

  task automatic drive(input logic r0, w0, l0, input logic [7:0] a0, input logic [15:0] d0,
                       input logic r1, w1, l1, input logic [7:0] a1, input logic [15:0] d1);
    p0_if.req = r0; p0_if.we = w0; p0_if.lock = l0; p0_if.addr = a0; p0_if.wdata = d0;
    p1_if.req = r1; p1_if.we = w1; p1_if.lock = l1; p1_if.addr = a1; p1_if.wdata = d1;
  endtask

  // Called just after a rising edge; drives one cycle and records what must happen.
  task automatic step(input logic r0, w0, l0, input logic [7:0] a0, input logic [15:0] d0,
                      input logic r1, w1, l1, input logic [7:0] a1, input logic [15:0] d1,
                      input logic [1:0] eg, input logic [15:0] erd);
    grec_t g;
    rrec_t r;
    drive(r0, w0, l0, a0, d0, r1, w1, l1, a1, d1);
    g.cyc  = cyc;
    g.g    = eg;
    g.wen  = (eg == G0) ? w0 : (eg == G1) ? w1 : 1'b0;
    g.addr = (eg == G1) ? a1 : a0;
    gq.push_back(g);
    if (eg != GN && !g.wen) begin
      r.cyc  = cyc + 1;
      r.port = (eg == G1) ? 1 : 0;
      r.data = erd;
      rq.push_back(r);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 8'h00, 16'h0, 0, 0, 0, 8'h00, 16'h0, GN, 16'h0);
  endtask

  initial begin
    grec_t g;
    drive(0, 0, 0, 8'h00, 16'h0, 0, 0, 0, 8'h00, 16'h0);

    // Reset holds grants off even with both ports writing.
    #2 drive(1, 1, 0, 8'h05, 16'hFFFF, 1, 1, 0, 8'h06, 16'hFFFF);
    #1;
    check("rst_p0_gnt", 32'(p0_if.gnt), 32'd0);
    check("rst_p1_gnt", 32'(p1_if.gnt), 32'd0);
    check("rst_w_en", 32'(ram_w_en), 32'd0);
    check("rst_rvalid", 32'({p1_if.rvalid, p0_if.rvalid}), 32'd0);
    @(posedge clk); #1;
    preload = 1'b0;
    drive(0, 0, 0, 8'h00, 16'h0, 0, 0, 0, 8'h00, 16'h0);
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;

    // Single p0 read.
    step(1, 0, 0, 8'h05, 16'h0, 0, 0, 0, 8'h00, 16'h0, G0, 16'h1234);
    idle();

    // p1 write then read-after-write.
    step(0, 0, 0, 8'h00, 16'h0, 1, 1, 0, 8'h10, 16'hBEEF, G1, 16'h0);
    step(0, 0, 0, 8'h00, 16'h0, 1, 0, 0, 8'h10, 16'h0, G1, 16'hBEEF);
    idle();

    // Both reading every cycle, no lock: strict alternation starting with p0.
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, 8'(32'h20 + (i + 1) / 2), 16'h0,
           1, 0, 0, 8'(32'h30 + i / 2), 16'h0,
           (i % 2 == 0) ? G0 : G1,
           (i % 2 == 0) ? 16'h2000 + 16'(i / 2) : 16'h3000 + 16'(i / 2));
    end
    idle();

    // p0 locked against continuous p1: four p0 grants, forced yield, then p0 again.
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 1, 8'h05, 16'h0, 1, 0, 0, 8'h06, 16'h0,
           (i == 4) ? G1 : G0, (i == 4) ? 16'h5A5A : 16'h1234);
    end
    idle();

    // p0 locked with p1 idle: never yields.
    for (int i = 0; i < 10; i++)
      step(1, 0, 1, 8'h05, 16'h0, 0, 0, 0, 8'h00, 16'h0, G0, 16'h1234);
    idle();
    // Burst restarts at 1 after the idle cycle, so p0 keeps winning under contention.
    step(1, 0, 1, 8'h05, 16'h0, 0, 0, 0, 8'h00, 16'h0, G0, 16'h1234);
    step(1, 0, 1, 8'h05, 16'h0, 1, 0, 0, 8'h06, 16'h0, G0, 16'h1234);
    idle();

    // Asynchronous reset right after a p0 read grant, during a p0 write.
    drive(1, 0, 0, 8'h05, 16'h0, 0, 0, 0, 8'h00, 16'h0);
    g.cyc = cyc; g.g = G0; g.wen = 1'b0; g.addr = 8'h05;
    gq.push_back(g);
    @(posedge clk); #1;
    drive(1, 1, 0, 8'h50, 16'hDEAD, 0, 0, 0, 8'h00, 16'h0);
    g.cyc = cyc; g.g = GN; g.wen = 1'b0; g.addr = 8'h00;
    gq.push_back(g);
    #1;
    check("pre_rst_rvalid", 32'(p0_if.rvalid), 32'd1);
    check("pre_rst_rdata", 32'(p0_if.rdata), 32'h1234);
    check("pre_rst_w_en", 32'(ram_w_en), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_p0_gnt", 32'(p0_if.gnt), 32'd0);
    check("mid_rst_p1_gnt", 32'(p1_if.gnt), 32'd0);
    check("mid_rst_w_en", 32'(ram_w_en), 32'd0);
    check("mid_rst_rvalid", 32'({p1_if.rvalid, p0_if.rvalid}), 32'd0);
    @(posedge clk);
    drive(0, 0, 0, 8'h00, 16'h0, 0, 0, 0, 8'h00, 16'h0);
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;

    // After release p0 wins the tie; the killed write never landed.
    step(1, 0, 0, 8'h50, 16'h0, 1, 0, 0, 8'h06, 16'h0, G0, 16'h0BAD);
    step(0, 0, 0, 8'h00, 16'h0, 1, 0, 0, 8'h06, 16'h0, G1, 16'h5A5A);
    idle();
    idle();

    check("grant_queue_drained", 32'(gq.size()), 32'd0);
    check("read_queue_drained", 32'(rq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
